stream_fetch_ctrl: RTL and testbench
====================================

STREAM_FETCH_CTRL -- requirements
Module: stream_fetch_ctrl

Interface
REQ-001 Parameter AXI_ID, default 6'd0: value driven on m_axi_arid.
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address added to req_addr to form the AXI address.
REQ-003 clk  in  1  single decoder clock; all logic on posedge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 flush  in  1  one-cycle pulse; invalidates the line buffer (new stream or seek).
REQ-006 req_rd  in  1  byte read request; held with req_addr until req_valid.
REQ-007 req_addr  in  32  stream byte offset.
REQ-008 req_data  out  8  requested byte.
REQ-009 req_valid  out  1  one-cycle pulse; req_data is valid.
REQ-010 m_axi_arvalid/arready  out/in  1/1  AXI read-address handshake.
REQ-011 m_axi_araddr  out  32; m_axi_arlen  out  4; m_axi_arsize  out  3; m_axi_arburst  out  2; m_axi_arid  out  6.
REQ-012 m_axi_rvalid/rready/rlast  in/out/in  1/1/1; m_axi_rdata  in  64.
REQ-013 err_rlast  out  1  sticky protocol-error flag.

Function
REQ-014 One 128-byte line buffer (16 x 64-bit beats) with tag = (BASE_ADDR+req_addr)[31:7] and one line_valid bit.
REQ-015 FSM states: IDLE, AR, RD, SERVE. Reset state is IDLE.
REQ-016 IDLE: req_rd with hit (line_valid, tag match) goes to SERVE; req_rd with miss latches the tag, clears line_valid and goes to AR.
REQ-017 AR: arvalid=1, araddr={tag,7'b0}, arlen=4'd15, arsize=3'd3, arburst=2'b01, arid=AXI_ID; go to RD on the cycle where arvalid&&arready.
REQ-018 RD: rready=1. Each rvalid beat is written to buffer entry beat_cnt, and beat_cnt increments (4-bit, starts at 0). At beat_cnt==15 the FSM sets line_valid and goes to IDLE; the original request is then re-evaluated and hits.
REQ-019 SERVE: req_data = beat[addr[6:3]][8*addr[2:0] +: 8] (little-endian lanes), registered. req_valid pulses for one cycle, then the FSM returns to IDLE.
REQ-020 Hit latency: req_valid exactly 2 cycles after req_rd is sampled in IDLE. Miss latency: 2 cycles after the 16th accepted beat.
REQ-021 req_rd low in IDLE: no action. The requester must not change req_addr while req_rd is high and req_valid has not yet arrived.
REQ-022 rlast asserted on a beat other than the 16th, or absent on the 16th: set err_rlast. The FSM still completes on beat count.
REQ-023 flush in IDLE or SERVE: clear line_valid next cycle. A pending SERVE completes.
REQ-024 flush in AR or RD: the burst runs to completion (AXI cannot be aborted), but line_valid stays 0 afterwards. Any held request then misses and refetches.
REQ-025 flush and a hit request in the same IDLE cycle: flush wins; the request is treated as a miss.
REQ-026 arvalid, once asserted, stays high with a stable araddr until arready.
REQ-027 BASE_ADDR+req_addr wraps modulo 2^32; line address increments without carry beyond bit 31.

Reset
REQ-028 On rst: state=IDLE, line_valid=0, beat_cnt=0, err_rlast=0, req_valid=0, req_data=0, arvalid=0, rready=0, araddr=0.
REQ-029 The arlen/arsize/arburst/arid outputs are constants and are unaffected by reset.
REQ-030 rst during AR or RD abandons the burst immediately. Clean recovery requires the AXI slave to be reset by the same rst.

Structure
REQ-031 AXI constants (BURST_INCR, SIZE_8B, LINE_BEATS=16) and the state enumeration belong in the shared decoder package.
REQ-032 The line buffer is one sub-module, stream_line_buf: 16x64, 1 write port, 1 registered read port.

Verification
REQ-033 Cold miss: BASE_ADDR=0, req_addr=0x85, arready immediate -> one AR with araddr=0x80, arlen=15; 16 beats; req_data = byte 5 of beat 0; err_rlast=0.
REQ-034 Hit run: sequential req_addr 0x80..0xFF after the fill -> 128 req_valid pulses, each 2 cycles after its req_rd, and no further AR.
REQ-035 Backpressure: arready delayed 7 cycles and rvalid random 25% -> araddr stable throughout, data correct, exactly 16 beats accepted.
REQ-036 Flush mid-burst at beat 9 -> burst completes, line_valid=0, held request triggers a second AR to the same address.
REQ-037 Early rlast on beat 10 -> err_rlast=1 and stays high until rst; the FSM still waits for 16 beats.
REQ-038 rst pulsed in RD -> all outputs at reset values the next cycle; a new request after reset refetches cleanly.

Source files
------------

// File: rtl/stream_fetch_ctrl_pkg.sv
// Shared constants for the stream fetch controller: AXI burst encodings, line geometry
// and FSM state codes.
package stream_fetch_ctrl_pkg;

  localparam int unsigned LINE_BEATS = 16;
  localparam logic [3:0]  LAST_BEAT  = 4'(LINE_BEATS - 1);
  localparam logic [3:0]  LINE_ARLEN = 4'(LINE_BEATS - 1);
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_8B    = 3'd3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAr    = 2'd1;
  localparam logic [1:0] StRd    = 2'd2;
  localparam logic [1:0] StServe = 2'd3;

  // Little-endian byte lane select within a 64-bit beat.
  function automatic logic [7:0] byte_lane(input logic [63:0] beat, input logic [2:0] lane);
    return beat[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/stream_line_buf.sv
// 16 x 64-bit line buffer: one write port, one registered read port.
module stream_line_buf
  import stream_fetch_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [63:0] wdata_i,
  input  logic [3:0]  raddr_i,
  output logic [63:0] rdata_o
);

  logic [63:0] mem_q [LINE_BEATS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/stream_fetch_ctrl.sv
// Single-line byte fetch cache: serves byte reads from a 128-byte line, refilling it
// with one 16-beat AXI INCR burst on a miss.
module stream_fetch_ctrl
  import stream_fetch_ctrl_pkg::*;
#(
  parameter logic [5:0]  AXI_ID    = 6'd0,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        req_rd_i,
  input  logic [31:0] req_addr_i,
  output logic [7:0]  req_data_o,
  output logic        req_valid_o,
  output logic        m_axi_arvalid_o,
  input  logic        m_axi_arready_i,
  output logic [31:0] m_axi_araddr_o,
  output logic [3:0]  m_axi_arlen_o,
  output logic [2:0]  m_axi_arsize_o,
  output logic [1:0]  m_axi_arburst_o,
  output logic [5:0]  m_axi_arid_o,
  input  logic        m_axi_rvalid_i,
  output logic        m_axi_rready_o,
  input  logic        m_axi_rlast_i,
  input  logic [63:0] m_axi_rdata_i,
  output logic        err_rlast_o
);

  logic [1:0]  state_q, state_d;
  logic        line_valid_q, line_valid_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        flushed_q, flushed_d;
  logic        err_q, err_d;
  logic [31:0] araddr_q, araddr_d;
  logic        req_valid_q, req_valid_d;
  logic [7:0]  req_data_q, req_data_d;

  logic [31:0] byte_addr;
  logic [24:0] req_tag;
  logic        hit;
  logic        beat_fire;
  logic        last_beat;
  logic [63:0] buf_rdata;

  assign byte_addr = BASE_ADDR + req_addr_i;
  assign req_tag   = byte_addr[31:7];
  // araddr_q doubles as the line tag; flush in the same cycle forces a miss.
  assign hit       = line_valid_q && !flush_i && (araddr_q[31:7] == req_tag);
  assign beat_fire = (state_q == StRd) && m_axi_rvalid_i;
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    beat_cnt_d   = beat_cnt_q;
    flushed_d    = flushed_q;
    err_d        = err_q;
    araddr_d     = araddr_q;
    req_valid_d  = 1'b0;
    req_data_d   = req_data_q;
    unique case (state_q)
      StIdle: begin
        if (flush_i) line_valid_d = 1'b0;
        if (req_rd_i) begin
          if (hit) begin
            state_d = StServe;
          end else begin
            line_valid_d = 1'b0;
            flushed_d    = 1'b0;
            araddr_d     = {req_tag, 7'b0};
            state_d      = StAr;
          end
        end
      end
      StAr: begin
        if (flush_i) flushed_d = 1'b1;
        if (m_axi_arready_i) state_d = StRd;
      end
      StRd: begin
        if (flush_i) flushed_d = 1'b1;
        if (m_axi_rvalid_i) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (m_axi_rlast_i != last_beat) err_d = 1'b1;
          if (last_beat) begin
            // A flush seen anywhere during the burst leaves the line invalid.
            line_valid_d = !(flushed_q || flush_i);
            state_d      = StIdle;
          end
        end
      end
      StServe: begin
        if (flush_i) line_valid_d = 1'b0;
        req_data_d  = byte_lane(buf_rdata, byte_addr[2:0]);
        req_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      line_valid_q <= 1'b0;
      beat_cnt_q   <= 4'd0;
      flushed_q    <= 1'b0;
      err_q        <= 1'b0;
      araddr_q     <= 32'h0;
      req_valid_q  <= 1'b0;
      req_data_q   <= 8'h0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      beat_cnt_q   <= beat_cnt_d;
      flushed_q    <= flushed_d;
      err_q        <= err_d;
      araddr_q     <= araddr_d;
      req_valid_q  <= req_valid_d;
      req_data_q   <= req_data_d;
    end
  end

  stream_line_buf u_line_buf (
    .clk_i   (clk_i),
    .we_i    (beat_fire),
    .waddr_i (beat_cnt_q),
    .wdata_i (m_axi_rdata_i),
    .raddr_i (byte_addr[6:3]),
    .rdata_o (buf_rdata)
  );

  assign req_data_o      = req_data_q;
  assign req_valid_o     = req_valid_q;
  assign m_axi_arvalid_o = (state_q == StAr);
  assign m_axi_araddr_o  = araddr_q;
  assign m_axi_arlen_o   = LINE_ARLEN;
  assign m_axi_arsize_o  = SIZE_8B;
  assign m_axi_arburst_o = BURST_INCR;
  assign m_axi_arid_o    = AXI_ID;
  assign m_axi_rready_o  = (state_q == StRd);
  assign err_rlast_o     = err_q;

endmodule

// File: tb/tb_stream_fetch_ctrl.sv
// Directed + randomized bench for stream_fetch_ctrl with an in-bench AXI slave and a
// line-level cache model.
module tb_stream_fetch_ctrl;

  localparam logic [5:0]  AxiId = 6'h2A;
  localparam logic [31:0] Base  = 32'h0;

  logic        clk = 1'b0;
  logic        rst, flush, req_rd;
  logic [31:0] req_addr;
  logic [7:0]  req_data;
  logic        req_valid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [5:0]  arid;
  logic        rvalid, rready, rlast;
  logic [63:0] rdata;
  logic        err_rlast;

  stream_fetch_ctrl #(.AXI_ID(AxiId), .BASE_ADDR(Base)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_rd_i(req_rd), .req_addr_i(req_addr),
    .req_data_o(req_data), .req_valid_o(req_valid),
    .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready), .m_axi_araddr_o(araddr),
    .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst),
    .m_axi_arid_o(arid), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .m_axi_rlast_i(rlast), .m_axi_rdata_i(rdata), .err_rlast_o(err_rlast)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0, cyc = 0;
  int ar_delay = 0, rvalid_pct = 100, rlast_err_idx = -1;
  int ar_wait = 0, beats_left = 0, beat_idx = 0, burst_beats = 0;
  int ar_count = 0, ar_unstable = 0;
  logic [31:0] burst_line, ar_first;
  logic [31:0] ar_log[$];
  logic [3:0]  hs_arlen;
  logic [2:0]  hs_arsize;
  logic [1:0]  hs_arburst;
  logic [5:0]  hs_arid;
  bit          model_valid = 1'b0;
  logic [31:0] model_line = '0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    return h[7:0];
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] addr);
    logic [31:0] full;
    full = Base + addr;
    return {full[31:7], 7'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decide AXI slave inputs for the coming posedge from the DUT's current outputs.
  task automatic slave_drive();
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    if (rst) begin
      ar_wait = 0; beats_left = 0;
      return;
    end
    if (arvalid === 1'b1) begin
      if (ar_wait == 0) ar_first = araddr;
      else if (araddr !== ar_first) ar_unstable++;
      if (ar_wait >= ar_delay) begin
        arready = 1'b1; ar_count++; ar_log.push_back(araddr);
        hs_arlen = arlen; hs_arsize = arsize; hs_arburst = arburst; hs_arid = arid;
        burst_line = araddr; beats_left = 16; beat_idx = 0; burst_beats = 0; ar_wait = 0;
      end else begin
        ar_wait++;
      end
    end else if (rready === 1'b1 && beats_left > 0 &&
                 int'($urandom_range(99)) < rvalid_pct) begin
      rvalid = 1'b1;
      for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem_byte(burst_line + 32'(beat_idx*8 + i));
      rlast = (beat_idx == 15) || (beat_idx == rlast_err_idx);
      beat_idx++; beats_left--; burst_beats++;
    end
  endtask

  task automatic tick();
    slave_drive();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_req(input logic [31:0] addr, input int flush_beat, input int ar0,
                        output bit got, output int lat, output logic [7:0] data);
    int t0;
    bit flushed;
    req_addr = addr; req_rd = 1'b1; t0 = cyc; got = 1'b0; flushed = 1'b0; lat = 0; data = '0;
    while (!got && cyc - t0 < 3000) begin
      flush = (flush_beat >= 0) && !flushed && (ar_count > ar0) && (beats_left > 0) &&
              (burst_beats == flush_beat);
      if (flush) flushed = 1'b1;
      tick();
      flush = 1'b0;
      if (req_valid === 1'b1) begin
        got = 1'b1; lat = cyc - t0; data = req_data;
      end
    end
    req_rd = 1'b0;
    check("req_timeout", 64'(got), 64'd1);
  endtask

  task automatic req_check(input logic [31:0] addr, input int flush_beat);
    logic [31:0] ln;
    bit exp_hit, got;
    int ar0, lat;
    logic [7:0] d;
    ln = line_of(addr);
    exp_hit = model_valid && (ln == model_line);
    ar0 = ar_count;
    do_req(addr, flush_beat, ar0, got, lat, d);
    check("req_data", 64'(d), 64'(mem_byte(Base + addr)));
    if (exp_hit) begin
      check("hit_latency", 64'(lat), 64'd2);
      check("hit_no_ar", 64'(ar_count - ar0), 64'd0);
    end else begin
      check("miss_ar_count", 64'(ar_count - ar0), (flush_beat >= 0) ? 64'd2 : 64'd1);
      check("miss_araddr", 64'(ar_log[$]), 64'(ln));
      check("miss_beats", 64'(burst_beats), 64'd16);
    end
    model_valid = 1'b1; model_line = ln;
  endtask

  task automatic flush_pulse();
    flush = 1'b1; tick(); flush = 1'b0;
    model_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    check({tag, "_rready"}, 64'(rready), 64'd0);
    check({tag, "_araddr"}, 64'(araddr), 64'd0);
    check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    check({tag, "_req_data"}, 64'(req_data), 64'd0);
    check({tag, "_err_rlast"}, 64'(err_rlast), 64'd0);
  endtask

  initial begin
    logic [31:0] lines [4];
    int guard;
    lines[0] = 32'h0000_1000; lines[1] = 32'h0000_1080;
    lines[2] = 32'hFFFF_FF80; lines[3] = 32'h0000_7F00;
    rst = 1'b1; flush = 1'b0; req_rd = 1'b0; req_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    check("const_arlen", 64'(arlen), 64'd15);
    check("const_arsize", 64'(arsize), 64'd3);
    check("const_arburst", 64'(arburst), 64'd1);
    check("const_arid", 64'(arid), 64'(AxiId));
    rst = 1'b0;
    tick();

    // Cold miss with immediate arready.
    req_check(32'h85, -1);
    check("cold_ar_total", 64'(ar_count), 64'd1);
    check("cold_hs_arlen", 64'(hs_arlen), 64'd15);
    check("cold_hs_arsize", 64'(hs_arsize), 64'd3);
    check("cold_hs_arburst", 64'(hs_arburst), 64'd1);
    check("cold_hs_arid", 64'(hs_arid), 64'(AxiId));
    check("cold_err_rlast", 64'(err_rlast), 64'd0);

    // Sequential hits over the whole line.
    for (int a = 'h80; a <= 'hFF; a++) req_check(32'(a), -1);
    check("hitrun_ar_total", 64'(ar_count), 64'd1);

    // Backpressure: slow arready, sparse rvalid.
    flush_pulse();
    ar_delay = 7; rvalid_pct = 25; ar_unstable = 0;
    req_check(32'h234, -1);
    check("bp_araddr_stable", 64'(ar_unstable), 64'd0);
    req_check(32'h23F, -1);

    // Randomized mix of hits, misses and flushes.
    for (int n = 0; n < 40; n++) begin
      ar_delay = int'($urandom_range(3));
      rvalid_pct = 30 + int'($urandom_range(70));
      if ($urandom_range(4) == 0) flush_pulse();
      req_check(lines[$urandom_range(3)] + 32'($urandom_range(127)), -1);
    end
    check("rand_araddr_stable", 64'(ar_unstable), 64'd0);

    // Flush after beat 9 of a burst: line stays invalid and the held request refetches.
    ar_delay = 0; rvalid_pct = 100;
    req_check(32'h300, 9);
    check("flush_first_ar", 64'(ar_log[$-1]), 64'h300);
    req_check(32'h301, -1);

    // Early rlast on beat 10 is sticky.
    rlast_err_idx = 9;
    req_check(32'h400, -1);
    check("early_rlast_err", 64'(err_rlast), 64'd1);
    rlast_err_idx = -1;
    req_check(32'h401, -1);
    flush_pulse();
    check("early_rlast_sticky", 64'(err_rlast), 64'd1);

    // Reset in the middle of a burst.
    flush_pulse();
    req_addr = 32'h500; req_rd = 1'b1;
    guard = 0;
    while (!(beats_left > 0 && burst_beats >= 5) && guard < 200) begin
      tick(); guard++;
    end
    check("rd_reached", 64'(guard < 200), 64'd1);
    req_rd = 1'b0; rst = 1'b1;
    tick();
    check_reset_outputs("rst_in_rd");
    rst = 1'b0; model_valid = 1'b0;
    tick();
    req_check(32'h500, -1);
    check("post_rst_err_rlast", 64'(err_rlast), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
